// File: rtl/disp7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver:
// hex glyph table (active-high gfedcba), scan state encoding, counter sizing.
package disp7_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_t;

  // Index = nibble value; bit 6..0 = segments g..a, 1 = segment lit.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_glyph.sv
// Combinational hex nibble to active-high gfedcba segment pattern.
// Zero latency; no flow control.
module seg7_hex_glyph
  import disp7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH[nibble];
  end

endmodule

// File: rtl/display_mux_7seg_n.sv
// N-digit time-multiplexed 7-segment scanner with frame-coherent shadow latch,
// per-digit blank/dp, dead-time between digits and 16-level PWM. Outputs registered (1 cycle).
module display_mux_7seg_n
  import disp7_pkg::*;
#(
  parameter int g_NUM_DIGITS   = 4,
  parameter int g_DIGIT_CYCLES = 100000,
  parameter int g_DEAD_CYCLES  = 1000,
  parameter int g_ACTIVE_LOW   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*g_NUM_DIGITS-1:0]   i_display_buffer,
  input  logic [g_NUM_DIGITS-1:0]     i_dp,
  input  logic [g_NUM_DIGITS-1:0]     i_blank,
  input  logic [3:0]                  i_brightness,
  output logic [g_NUM_DIGITS-1:0]     o_anodes,
  output logic [6:0]                  o_cathodes,
  output logic                        o_dp,
  output logic                        o_frame_tick
);

  localparam int SLOT_W = cnt_width(g_DIGIT_CYCLES);
  localparam int IDX_W  = cnt_width(g_NUM_DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(g_DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(g_DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(g_NUM_DIGITS - 1);
  localparam logic              INACT     = (g_ACTIVE_LOW != 0);

  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_nxt;
  logic [IDX_W-1:0]  digit_idx;
  logic [3:0]        pwm_cnt;
  state_t            state;

  logic [g_NUM_DIGITS-1:0][3:0] shadow_buf;
  logic [g_NUM_DIGITS-1:0]      shadow_dp;
  logic [g_NUM_DIGITS-1:0]      shadow_blank;
  logic [3:0]                   shadow_bright;

  logic                    slot_wrap;
  logic                    frame_start;
  logic                    pwm_ok;
  logic                    lit;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_seg;
  logic [g_NUM_DIGITS-1:0] anode_hot;

  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign slot_nxt    = slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
  assign frame_start = (slot_cnt == '0) && (digit_idx == '0);
  assign cur_nib     = shadow_buf[digit_idx];

  // Level 15 bypasses the comparator so full brightness has no off cycle.
  assign pwm_ok = (shadow_bright == 4'hF) || (pwm_cnt < shadow_bright);
  assign lit    = (state == S_ON) && !shadow_blank[digit_idx] && pwm_ok;

  always_comb begin
    anode_hot            = '0;
    anode_hot[digit_idx] = 1'b1;
  end

  seg7_hex_glyph u_glyph (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt      <= '0;
      digit_idx     <= '0;
      pwm_cnt       <= '0;
      state         <= S_BLANK;
      shadow_buf    <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '0;
      shadow_bright <= '0;
      o_anodes      <= {g_NUM_DIGITS{INACT}};
      o_cathodes    <= {7{INACT}};
      o_dp          <= INACT;
      o_frame_tick  <= 1'b0;
    end else begin
      slot_cnt <= slot_nxt;
      pwm_cnt  <= pwm_cnt + 4'd1;
      if (slot_wrap) begin
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      end

      // State tracks the slot counter value it will sit beside next cycle.
      state <= (slot_nxt >= DEAD_END) ? S_ON : S_BLANK;

      if (frame_start) begin
        shadow_buf    <= i_display_buffer;
        shadow_dp     <= i_dp;
        shadow_blank  <= i_blank;
        shadow_bright <= i_brightness;
      end
      o_frame_tick <= frame_start;

      if (lit) begin
        o_anodes   <= anode_hot ^ {g_NUM_DIGITS{INACT}};
        o_cathodes <= cur_seg ^ {7{INACT}};
        o_dp       <= shadow_dp[digit_idx] ^ INACT;
      end else begin
        o_anodes   <= {g_NUM_DIGITS{INACT}};
        o_cathodes <= {7{INACT}};
        o_dp       <= INACT;
      end
    end
  end

endmodule
